// File: rtl/imem_dmem_arb_pkg.sv
// imem_dmem_arb_pkg: shared types and constants for the imem/dmem port arbiter
package imem_dmem_arb_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;
  localparam logic [31:0] RSP_STORE_ACK = 32'h0;
endpackage

// File: rtl/arb_starve_prio.sv
// arb_starve_prio: LS-priority grant with a saturating starve counter that forces an IF win
module arb_starve_prio
  import imem_dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  logic force_if;
  assign force_if = (starve == SW'(STARVE_MAX)) && if_valid;
  assign grant_if = accept && (force_if || (!ls_valid && if_valid));
  assign grant_ls = accept && !force_if && ls_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve <= '0;
    else if (grant_if) starve <= '0;
    else if (grant_ls && if_valid && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
  end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one synchronous-read memory port between fetch and load/store
module imem_dmem_arbiter
  import imem_dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [31:0]       if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [31:0]       ls_req_addr,
  input  logic [31:0]       ls_req_wdata,
  input  logic [3:0]        ls_req_wstrb,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [31:0]       ls_rsp_data,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  state_t state, state_n;
  owner_t owner;
  logic [CW-1:0] cnt;
  logic store_q, flush_q, resp, accept, grant_if, grant_ls, hs;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], if_req_addr[1:0],
                              ls_req_addr[31:ADDR_W+2], ls_req_addr[1:0]};
  assign resp   = (state == WAIT) && (cnt == CW'(READ_LATENCY - 1));
  // Async reset also masks the accept window so nothing leaks out while rst is high
  assign accept = !rst && ((state == IDLE) || resp);
  arb_starve_prio #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .if_valid(if_req_valid),
    .ls_valid(ls_req_valid),
    .grant_if(grant_if),
    .grant_ls(grant_ls)
  );
  assign hs           = grant_if || grant_ls;
  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign mem_en       = hs;
  assign mem_we       = (grant_ls && ls_req_we) ? ls_req_wstrb : 4'h0;
  assign mem_addr     = grant_ls ? ls_req_addr[ADDR_W+1:2] : grant_if ? if_req_addr[ADDR_W+1:2] : '0;
  assign mem_wdata    = grant_ls ? ls_req_wdata : 32'h0;
  assign if_rsp_valid = resp && (owner == OWN_IF) && !flush_q && !if_flush;
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : 32'h0;
  assign ls_rsp_valid = resp && (owner == OWN_LS);
  assign ls_rsp_data  = (ls_rsp_valid && !store_q) ? mem_rdata : RSP_STORE_ACK;
  always_comb begin
    state_n = hs ? WAIT : (state == WAIT && !resp) ? WAIT : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= OWN_NONE;
      store_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= (hs || resp || state != WAIT) ? '0 : cnt + 1'b1;
      owner   <= hs ? (grant_if ? OWN_IF : OWN_LS) : resp ? OWN_NONE : owner;
      store_q <= hs ? (grant_ls && ls_req_we) : store_q;
      // A response cycle always retires the flag, so a request accepted there is never flushed
      flush_q <= resp ? 1'b0 : (state == WAIT && owner == OWN_IF && if_flush) ? 1'b1 : flush_q;
    end
  end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed checks of the arbiter at read latency 1 (a_*) and 3 (b_*)
module tb_imem_dmem_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic        a_if_req_valid, a_if_flush, a_ls_req_valid, a_ls_req_we;
  logic [31:0] a_if_req_addr, a_ls_req_addr, a_ls_req_wdata;
  logic [3:0]  a_ls_req_wstrb;
  logic        a_if_req_ready, a_if_rsp_valid, a_ls_req_ready, a_ls_rsp_valid, a_mem_en;
  logic [31:0] a_if_rsp_data, a_ls_rsp_data, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_we;
  logic [13:0] a_mem_addr;
  logic        b_if_req_valid, b_if_flush, b_ls_req_valid, b_ls_req_we;
  logic [31:0] b_if_req_addr, b_ls_req_addr, b_ls_req_wdata;
  logic [3:0]  b_ls_req_wstrb;
  logic        b_if_req_ready, b_if_rsp_valid, b_ls_req_ready, b_ls_rsp_valid, b_mem_en;
  logic [31:0] b_if_rsp_data, b_ls_rsp_data, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_we;
  logic [13:0] b_mem_addr;
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] b_p0, b_p1;

  imem_dmem_arbiter #(.ADDR_W(14), .READ_LATENCY(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(a_if_req_valid), .if_req_addr(a_if_req_addr), .if_req_ready(a_if_req_ready),
    .if_flush(a_if_flush), .if_rsp_valid(a_if_rsp_valid), .if_rsp_data(a_if_rsp_data),
    .ls_req_valid(a_ls_req_valid), .ls_req_we(a_ls_req_we), .ls_req_addr(a_ls_req_addr),
    .ls_req_wdata(a_ls_req_wdata), .ls_req_wstrb(a_ls_req_wstrb), .ls_req_ready(a_ls_req_ready),
    .ls_rsp_valid(a_ls_rsp_valid), .ls_rsp_data(a_ls_rsp_data),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );
  imem_dmem_arbiter #(.ADDR_W(14), .READ_LATENCY(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
    .if_flush(b_if_flush), .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
    .ls_req_valid(b_ls_req_valid), .ls_req_we(b_ls_req_we), .ls_req_addr(b_ls_req_addr),
    .ls_req_wdata(b_ls_req_wdata), .ls_req_wstrb(b_ls_req_wstrb), .ls_req_ready(b_ls_req_ready),
    .ls_rsp_valid(b_ls_rsp_valid), .ls_rsp_data(b_ls_rsp_data),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  always @(posedge clk) begin
    if (a_mem_en) begin
      a_mem_rdata <= mem_a[a_mem_addr[7:0]];
      for (int k = 0; k < 4; k++) if (a_mem_we[k]) mem_a[a_mem_addr[7:0]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    end
  end
  always @(posedge clk) begin
    if (b_mem_en) b_p0 <= mem_b[b_mem_addr[7:0]];
    b_p1 <= b_p0;
    b_mem_rdata <= b_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if ({a_if_req_ready, a_ls_req_ready, a_if_rsp_valid, a_ls_rsp_valid, a_if_rsp_data, a_ls_rsp_data,
         a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    rst = 0;
    tick();
    a_if_req_valid = 1; a_if_req_addr = 32'h8; #1;
    total++;
    if ({a_if_req_ready, a_mem_en, a_mem_addr} !== {1'b1, 1'b1, 14'd2}) begin
      bad++; $display("FAIL reset_pre_req: got rdy=%b en=%b addr=%0d want 1 1 2", a_if_req_ready, a_mem_en, a_mem_addr);
    end
    tick();
    a_if_req_valid = 0;
    rst = 1; #1;
    total++;
    if ({a_if_rsp_valid, a_if_rsp_data, a_mem_en, a_if_req_ready} !== '0) begin
      bad++; $display("FAIL reset_midflight: got rsp_valid=%b data=%h, want 0 0", a_if_rsp_valid, a_if_rsp_data);
    end
    tick();
    rst = 0;
    tick();
    total++;
    if (a_if_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_late_rsp: got %b want 0", a_if_rsp_valid);
    end
    a_if_req_valid = 1; a_if_req_addr = 32'h0; #1;
    total++;
    if ({a_if_req_ready, a_mem_addr} !== {1'b1, 14'd0}) begin
      bad++; $display("FAIL reset_first_req: got rdy=%b addr=%0d want 1 0", a_if_req_ready, a_mem_addr);
    end
    tick();
    a_if_req_valid = 0; #1;
    total++;
    if ({a_if_rsp_valid, a_if_rsp_data} !== {1'b1, 32'hA000_0000}) begin
      bad++; $display("FAIL reset_first_rsp: got v=%b d=%h want 1 a0000000", a_if_rsp_valid, a_if_rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    want[0] = 32'hA000_0000; want[1] = 32'hA000_0001; want[2] = 32'hA000_0002;
    for (int i = 0; i < 4; i++) begin
      a_if_req_valid = (i < 3);
      a_if_req_addr  = 32'(4 * i); #1;
      if (i < 3) begin
        total++;
        if (a_if_req_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, a_if_req_ready);
        end
      end
      if (i > 0) begin
        total++;
        if ({a_if_rsp_valid, a_if_rsp_data} !== {1'b1, want[i-1]}) begin
          bad++; $display("FAIL b2b_rsp%0d: got v=%b d=%h want 1 %h", i - 1, a_if_rsp_valid, a_if_rsp_data, want[i-1]);
        end
      end
      tick();
    end
    a_if_req_valid = 0; #1;
    total++;
    if (a_if_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got %b want 0", a_if_rsp_valid);
    end
  endtask

  task automatic test_conflict();
    a_if_req_valid = 1; a_if_req_addr = 32'hC;
    a_ls_req_valid = 1; a_ls_req_we = 0; a_ls_req_addr = 32'h100; #1;
    total++;
    if ({a_ls_req_ready, a_if_req_ready, a_mem_addr, a_mem_we} !== {1'b1, 1'b0, 14'd64, 4'h0}) begin
      bad++; $display("FAIL conflict_grant: got ls=%b if=%b addr=%0d want 1 0 64", a_ls_req_ready, a_if_req_ready, a_mem_addr);
    end
    tick();
    a_ls_req_valid = 0; #1;
    total++;
    if ({a_ls_rsp_valid, a_ls_rsp_data, a_if_req_ready, a_mem_addr} !== {1'b1, 32'hA000_0040, 1'b1, 14'd3}) begin
      bad++; $display("FAIL conflict_rsp: got v=%b d=%h ifrdy=%b addr=%0d want 1 a0000040 1 3",
                      a_ls_rsp_valid, a_ls_rsp_data, a_if_req_ready, a_mem_addr);
    end
    tick();
    a_if_req_valid = 0; #1;
    total++;
    if ({a_if_rsp_valid, a_if_rsp_data, a_ls_rsp_valid} !== {1'b1, 32'hA000_0003, 1'b0}) begin
      bad++; $display("FAIL conflict_if_rsp: got v=%b d=%h want 1 a0000003", a_if_rsp_valid, a_if_rsp_data);
    end
    tick();
  endtask

  task automatic test_starve();
    a_if_req_valid = 1; a_if_req_addr = 32'h14;
    a_ls_req_valid = 1; a_ls_req_we = 0; a_ls_req_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if ({a_if_req_ready, a_ls_req_ready} !== ((i == 4) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL starve_win%0d: got if=%b ls=%b want %b", i, a_if_req_ready, a_ls_req_ready,
                        (i == 4) ? 2'b10 : 2'b01);
      end
      if (i == 5) begin
        total++;
        if ({a_if_rsp_valid, a_if_rsp_data} !== {1'b1, 32'hA000_0005}) begin
          bad++; $display("FAIL starve_if_rsp: got v=%b d=%h want 1 a0000005", a_if_rsp_valid, a_if_rsp_data);
        end
      end
      tick();
    end
    a_if_req_valid = 0; a_ls_req_valid = 0; #1;
    total++;
    if ({a_ls_rsp_valid, a_ls_rsp_data} !== {1'b1, 32'hA000_0008}) begin
      bad++; $display("FAIL starve_ls_rsp: got v=%b d=%h want 1 a0000008", a_ls_rsp_valid, a_ls_rsp_data);
    end
    tick();
  endtask

  task automatic test_store();
    a_ls_req_valid = 1; a_ls_req_we = 1; a_ls_req_addr = 32'h10;
    a_ls_req_wdata = 32'hDEAD_BEEF; a_ls_req_wstrb = 4'b0011; #1;
    total++;
    if ({a_ls_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 4'b0011, 14'd4, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL store_req: got rdy=%b en=%b we=%b addr=%0d wd=%h want 1 1 0011 4 deadbeef",
                      a_ls_req_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    tick();
    a_ls_req_we = 0; #1;
    total++;
    if ({a_ls_rsp_valid, a_ls_rsp_data, a_mem_we} !== {1'b1, 32'h0, 4'h0}) begin
      bad++; $display("FAIL store_ack: got v=%b d=%h we=%b want 1 0 0", a_ls_rsp_valid, a_ls_rsp_data, a_mem_we);
    end
    tick();
    a_ls_req_valid = 0; #1;
    total++;
    if ({a_ls_rsp_valid, a_ls_rsp_data} !== {1'b1, 32'hA000_BEEF}) begin
      bad++; $display("FAIL store_readback: got v=%b d=%h want 1 a000beef", a_ls_rsp_valid, a_ls_rsp_data);
    end
    tick();
  endtask

  task automatic test_flush();
    b_if_req_valid = 1; b_if_req_addr = 32'h18; #1;
    total++;
    if (b_if_req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_req0: got %b want 1", b_if_req_ready);
    end
    tick();
    b_if_req_valid = 0; b_if_flush = 1; #1;
    total++;
    if ({b_if_rsp_valid, b_if_req_ready} !== 2'b00) begin
      bad++; $display("FAIL flush_wait1: got v=%b rdy=%b want 0 0", b_if_rsp_valid, b_if_req_ready);
    end
    tick();
    b_if_flush = 0;
    tick();
    b_if_req_valid = 1; b_if_req_addr = 32'h1C; #1;
    total++;
    if ({b_if_rsp_valid, b_if_req_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_suppress: got v=%b rdy=%b want 0 1", b_if_rsp_valid, b_if_req_ready);
    end
    tick();
    b_if_req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (b_if_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL flush_early%0d: got %b want 0", i, b_if_rsp_valid);
      end
      tick();
    end
    total++;
    if ({b_if_rsp_valid, b_if_rsp_data} !== {1'b1, 32'hA000_0007}) begin
      bad++; $display("FAIL flush_next_rsp: got v=%b d=%h want 1 a0000007", b_if_rsp_valid, b_if_rsp_data);
    end
    tick();
    b_if_req_valid = 1; b_if_req_addr = 32'h24; #1;
    tick();
    b_if_req_valid = 0;
    tick(); tick();
    b_if_flush = 1; #1;
    total++;
    if (b_if_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_same_cycle: got %b want 0", b_if_rsp_valid);
    end
    tick();
    b_ls_req_valid = 1; b_ls_req_we = 0; b_ls_req_addr = 32'h28; #1;
    tick();
    b_ls_req_valid = 0;
    tick(); tick(); #1;
    total++;
    if ({b_ls_rsp_valid, b_ls_rsp_data} !== {1'b1, 32'hA000_000A}) begin
      bad++; $display("FAIL flush_ls_unaffected: got v=%b d=%h want 1 a000000a", b_ls_rsp_valid, b_ls_rsp_data);
    end
    b_if_flush = 0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hA000_0000 + 32'(i);
      mem_b[i] = 32'hA000_0000 + 32'(i);
    end
    {a_if_req_valid, a_if_flush, a_ls_req_valid, a_ls_req_we} = '0;
    {a_if_req_addr, a_ls_req_addr, a_ls_req_wdata, a_ls_req_wstrb} = '0;
    {b_if_req_valid, b_if_flush, b_ls_req_valid, b_ls_req_we} = '0;
    {b_if_req_addr, b_ls_req_addr, b_ls_req_wdata, b_ls_req_wstrb} = '0;
    test_reset();
    test_back_to_back();
    test_conflict();
    test_starve();
    test_store();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
